// File: rtl/snn_layer_controller_if.sv
// ---------------------------------------------------------------------------
// snn_layer_controller_if
// Step handshake, weight-write port and output spike bus of the spiking layer.
//   input_spike  : spike vector for one time step (master -> slave)
//   step_valid   : input_spike valid              (master -> slave)
//   step_ready   : layer can accept a step        (slave  -> master)
//   w_we         : weight write strobe            (master -> slave)
//   w_addr_in    : weight row, presynaptic index  (master -> slave)
//   w_addr_out   : weight column, neuron index    (master -> slave)
//   w_data       : signed weight value            (master -> slave)
//   output_spike : spike vector of the last step  (slave  -> master)
//   out_valid    : one-cycle pulse, output updated (slave -> master)
// ---------------------------------------------------------------------------
interface snn_layer_controller_if #(
    parameter int NUM_IN  = 8,
    parameter int NUM_OUT = 8,
    parameter int W_WIDTH = 8
);
    localparam int AI = (NUM_IN  > 1) ? $clog2(NUM_IN)  : 1;
    localparam int AO = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    logic [NUM_IN-1:0]         input_spike;
    logic                      step_valid;
    logic                      step_ready;
    logic                      w_we;
    logic [AI-1:0]             w_addr_in;
    logic [AO-1:0]             w_addr_out;
    logic signed [W_WIDTH-1:0] w_data;
    logic [NUM_OUT-1:0]        output_spike;
    logic                      out_valid;

    modport master (
        output input_spike, step_valid, w_we, w_addr_in, w_addr_out, w_data,
        input  step_ready, output_spike, out_valid
    );

    modport slave (
        input  input_spike, step_valid, w_we, w_addr_in, w_addr_out, w_data,
        output step_ready, output_spike, out_valid
    );
endinterface

// File: rtl/snn_layer_controller.sv
// ---------------------------------------------------------------------------
// snn_layer_controller
// One layer of leaky integrate-and-fire neurons. A step is accepted in IDLE,
// the captured spike vector is integrated one presynaptic row per cycle
// (NUM_IN cycles, all neurons in parallel), then a single FIRE cycle applies
// leak, threshold, reset and refractory handling and registers the result.
// Ports:
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset (clears weights and neuron state)
//   bus     : snn_layer_controller_if.slave (step handshake, weights, output)
// ---------------------------------------------------------------------------
module snn_layer_controller #(
    parameter int NUM_IN     = 8,
    parameter int NUM_OUT    = 8,
    parameter int W_WIDTH    = 8,
    parameter int V_WIDTH    = 16,
    parameter int THRESHOLD  = 64,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2,
    parameter int RESET_MODE = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    snn_layer_controller_if.slave  bus
);
    localparam int AI = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic signed [V_WIDTH-1:0] THR_V = V_WIDTH'(THRESHOLD);
    localparam logic signed [V_WIDTH-1:0] V_MAX = {1'b0, {(V_WIDTH-1){1'b1}}};
    localparam logic signed [V_WIDTH-1:0] V_MIN = {1'b1, {(V_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FIRE  = 2'd2
    } state_t;

    state_t                    state_r;
    logic [NUM_IN-1:0]         spikes_r;
    logic [AI-1:0]             idx_r;
    logic signed [W_WIDTH-1:0] w_r      [NUM_IN][NUM_OUT];
    logic signed [V_WIDTH-1:0] v_r      [NUM_OUT];
    logic [RW-1:0]             refrac_r [NUM_OUT];
    logic [NUM_OUT-1:0]        spike_out_r;
    logic                      out_valid_r;
    logic                      step_ready_r;

    logic signed [V_WIDTH-1:0] vl_s     [NUM_OUT];
    logic signed [V_WIDTH-1:0] v_fire_s [NUM_OUT];
    logic [NUM_OUT-1:0]        fire_s;
    logic                      w_addr_ok_s;

    // Saturating add of a sign-extended weight; overflow shows as the two top
    // bits of the one-bit-wider sum disagreeing.
    function automatic logic signed [V_WIDTH-1:0] sat_add(
        input logic signed [V_WIDTH-1:0] a,
        input logic signed [W_WIDTH-1:0] b
    );
        logic signed [V_WIDTH:0] s;
        s = {a[V_WIDTH-1], a} + {{(V_WIDTH+1-W_WIDTH){b[W_WIDTH-1]}}, b};
        if (s[V_WIDTH] != s[V_WIDTH-1]) begin
            return s[V_WIDTH] ? V_MIN : V_MAX;
        end else begin
            return s[V_WIDTH-1:0];
        end
    endfunction

    // Leaked potential; |v - (v >>> k)| <= |v| so this cannot overflow.
    function automatic logic signed [V_WIDTH-1:0] leak(
        input logic signed [V_WIDTH-1:0] v
    );
        return v - (v >>> LEAK_SHIFT);
    endfunction

    assign bus.step_ready   = step_ready_r;
    assign bus.output_spike = spike_out_r;
    assign bus.out_valid    = out_valid_r;

    // Per-neuron leak, threshold decision and post-fire potential.
    always_comb begin
        w_addr_ok_s = (32'(bus.w_addr_in) < NUM_IN) && (32'(bus.w_addr_out) < NUM_OUT);
        for (int j = 0; j < NUM_OUT; j++) begin
            vl_s[j]   = leak(v_r[j]);
            fire_s[j] = (vl_s[j] >= THR_V);
            if (RESET_MODE == 1) begin
                v_fire_s[j] = vl_s[j] - THR_V;
            end else begin
                v_fire_s[j] = {V_WIDTH{1'b0}};
            end
        end
    end

    // Layer FSM with weight memory, neuron state and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            step_ready_r <= 1'b1;
            out_valid_r  <= 1'b0;
            spike_out_r  <= {NUM_OUT{1'b0}};
            spikes_r     <= {NUM_IN{1'b0}};
            idx_r        <= {AI{1'b0}};
            for (int i = 0; i < NUM_IN; i++) begin
                for (int j = 0; j < NUM_OUT; j++) begin
                    w_r[i][j] <= {W_WIDTH{1'b0}};
                end
            end
            for (int j = 0; j < NUM_OUT; j++) begin
                v_r[j]      <= {V_WIDTH{1'b0}};
                refrac_r[j] <= {RW{1'b0}};
            end
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // A write in the accepting cycle lands before ACCUM reads.
                    if (bus.w_we && w_addr_ok_s) begin
                        w_r[bus.w_addr_in][bus.w_addr_out] <= bus.w_data;
                    end
                    if (bus.step_valid) begin
                        spikes_r     <= bus.input_spike;
                        idx_r        <= {AI{1'b0}};
                        step_ready_r <= 1'b0;
                        state_r      <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (spikes_r[idx_r]) begin
                        for (int j = 0; j < NUM_OUT; j++) begin
                            v_r[j] <= sat_add(v_r[j], w_r[idx_r][j]);
                        end
                    end
                    if (idx_r == AI'(NUM_IN - 1)) begin
                        state_r <= FIRE;
                    end else begin
                        idx_r <= idx_r + 1'b1;
                    end
                end
                FIRE: begin
                    for (int j = 0; j < NUM_OUT; j++) begin
                        if (refrac_r[j] != {RW{1'b0}}) begin
                            v_r[j]         <= {V_WIDTH{1'b0}};
                            refrac_r[j]    <= refrac_r[j] - 1'b1;
                            spike_out_r[j] <= 1'b0;
                        end else if (fire_s[j]) begin
                            v_r[j]         <= v_fire_s[j];
                            refrac_r[j]    <= RW'(REFRAC);
                            spike_out_r[j] <= 1'b1;
                        end else begin
                            v_r[j]         <= vl_s[j];
                            spike_out_r[j] <= 1'b0;
                        end
                    end
                    out_valid_r  <= 1'b1;
                    step_ready_r <= 1'b1;
                    state_r      <= IDLE;
                end
                default: begin
                    state_r      <= IDLE;
                    step_ready_r <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_snn_layer_controller.sv
// ---------------------------------------------------------------------------
// tb_snn_layer_controller
// Directed bench: two layers (zero-on-fire and subtract-on-fire) driven in
// lockstep from a table of steps, plus hand sequences for reset, same-cycle
// write/accept, held step_valid, write during ACCUM and reset abort.
// ---------------------------------------------------------------------------
module tb_snn_layer_controller;
    logic              clk;
    logic              reset_n;
    logic [7:0]        input_spike;
    logic              step_valid;
    logic              w_we;
    logic [2:0]        w_addr_in;
    logic [2:0]        w_addr_out;
    logic signed [7:0] w_data;

    int checks   = 0;
    int failures = 0;

    snn_layer_controller_if #(.NUM_IN(8), .NUM_OUT(8), .W_WIDTH(8)) bus0 ();
    snn_layer_controller_if #(.NUM_IN(8), .NUM_OUT(8), .W_WIDTH(8)) bus1 ();

    assign bus0.input_spike = input_spike;
    assign bus0.step_valid  = step_valid;
    assign bus0.w_we        = w_we;
    assign bus0.w_addr_in   = w_addr_in;
    assign bus0.w_addr_out  = w_addr_out;
    assign bus0.w_data      = w_data;
    assign bus1.input_spike = input_spike;
    assign bus1.step_valid  = step_valid;
    assign bus1.w_we        = w_we;
    assign bus1.w_addr_in   = w_addr_in;
    assign bus1.w_addr_out  = w_addr_out;
    assign bus1.w_data      = w_data;

    snn_layer_controller #(.RESET_MODE(0)) dut (.clk(clk), .reset_n(reset_n), .bus(bus0));
    snn_layer_controller #(.RESET_MODE(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit                do_rst;
        bit                wr_all;
        bit                wr_one;
        logic signed [7:0] w_val;
        logic [7:0]        spike;
        logic [7:0]        exp0;
        logic [7:0]        exp1;
        int                ev0;
        int                ev1;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic write_w(input int i, input int j, input int val);
        @(negedge clk);
        w_we       = 1'b1;
        w_addr_in  = 3'(i);
        w_addr_out = 3'(j);
        w_data     = 8'(val);
        @(negedge clk);
        w_we = 1'b0;
    endtask

    // Wait (bounded) for out_valid after an accepting edge; returns edge count.
    task automatic wait_ov(output int n, output int ready_bad);
        n = 0;
        ready_bad = 0;
        while (n < 20) begin
            if (bus0.step_ready !== 1'b0 || bus1.step_ready !== 1'b0) ready_bad++;
            @(posedge clk);
            #1;
            n++;
            if (bus0.out_valid === 1'b1) break;
        end
    endtask

    task automatic run_step(input string name, input logic [7:0] spike,
                            input logic [7:0] exp0, input logic [7:0] exp1,
                            input int ev0, input int ev1);
        int n;
        int ready_bad;
        @(negedge clk);
        input_spike = spike;
        step_valid  = 1'b1;
        @(posedge clk);
        #1;
        step_valid = 1'b0;
        wait_ov(n, ready_bad);
        chk({name, "_latency"}, n, 9);
        chk({name, "_ready_low"}, ready_bad, 0);
        chk({name, "_ov1"}, bus1.out_valid, 1);
        chk({name, "_out0"}, bus0.output_spike, exp0);
        chk({name, "_out1"}, bus1.output_spike, exp1);
        chk({name, "_ready"}, bus0.step_ready, 1);
        chk({name, "_v0"}, dut.v_r[0], ev0);
        chk({name, "_v1"}, dut1.v_r[0], ev1);
        @(posedge clk);
        #1;
        chk({name, "_ov_pulse"}, bus0.out_valid, 0);
        chk({name, "_hold"}, bus0.output_spike, exp0);
    endtask

    initial begin
        int n;
        int rb;
        int pulses;
        int first_pos;
        int last_pos;
        int bad;

        reset_n     = 1'b0;
        input_spike = 8'h00;
        step_valid  = 1'b0;
        w_we        = 1'b0;
        w_addr_in   = 3'd0;
        w_addr_out  = 3'd0;
        w_data      = 8'sd0;

        //          rst   all   one   w        spike  exp0   exp1   v0   v1
        vecs[0] = '{1'b1, 1'b1, 1'b0, 8'sd10,  8'hFF, 8'hFF, 8'hFF, 0,   6};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 8'sd0,   8'hFF, 8'h00, 8'h00, 0,   0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 8'sd0,   8'hFF, 8'h00, 8'h00, 0,   0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 8'sd0,   8'hFF, 8'hFF, 8'hFF, 0,   6};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 8'sd40,  8'h01, 8'h00, 8'h00, 35,  35};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 8'sd0,   8'h01, 8'h01, 8'h01, 0,   2};
        vecs[6] = '{1'b1, 1'b1, 1'b0, -8'sd10, 8'hFF, 8'h00, 8'h00, -70, -70};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 8'sd0,   8'h00, 8'h00, 8'h00, -61, -61};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", bus0.output_spike, 8'h00);
        chk("rst_ov", bus0.out_valid, 0);
        chk("rst_ready", bus0.step_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_ready", bus0.step_ready, 1);

        // Table-driven steps
        for (int k = 0; k < 8; k++) begin
            if (vecs[k].do_rst) do_reset();
            if (vecs[k].wr_all) begin
                for (int i = 0; i < 8; i++)
                    for (int j = 0; j < 8; j++)
                        write_w(i, j, int'(vecs[k].w_val));
            end
            if (vecs[k].wr_one) write_w(0, 0, int'(vecs[k].w_val));
            run_step($sformatf("vec%0d", k), vecs[k].spike, vecs[k].exp0,
                     vecs[k].exp1, vecs[k].ev0, vecs[k].ev1);
        end

        // Weight write and step acceptance in the same IDLE cycle
        do_reset();
        @(negedge clk);
        w_we        = 1'b1;
        w_addr_in   = 3'd0;
        w_addr_out  = 3'd0;
        w_data      = 8'sd80;
        input_spike = 8'h01;
        step_valid  = 1'b1;
        @(posedge clk);
        #1;
        w_we       = 1'b0;
        step_valid = 1'b0;
        wait_ov(n, rb);
        chk("samecyc_latency", n, 9);
        chk("samecyc_out0", bus0.output_spike, 8'h01);
        chk("samecyc_v1", dut1.v_r[0], 6);

        // step_valid held high; weight write attempted during ACCUM
        do_reset();
        for (int j = 0; j < 8; j++) write_w(0, j, 10);
        @(negedge clk);
        input_spike = 8'hFF;
        step_valid  = 1'b1;
        @(posedge clk);
        #1;
        pulses = 0;
        first_pos = 0;
        last_pos = 0;
        for (int k = 1; k <= 19; k++) begin
            if (k == 4) begin
                w_we       = 1'b1;
                w_addr_in  = 3'd0;
                w_addr_out = 3'd0;
                w_data     = 8'sd127;
            end else begin
                w_we = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus0.out_valid === 1'b1) begin
                pulses++;
                if (first_pos == 0) first_pos = k;
                last_pos = k;
            end
        end
        step_valid = 1'b0;
        w_we       = 1'b0;
        chk("held_pulses", pulses, 2);
        chk("held_first", first_pos, 9);
        chk("held_second", last_pos, 19);
        chk("accum_write_ignored", dut.w_r[0][0], 10);

        // Reset during ACCUM aborts the step
        @(negedge clk);
        input_spike = 8'hFF;
        step_valid  = 1'b1;
        @(posedge clk);
        #1;
        step_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("abort_ready", bus0.step_ready, 1);
        @(posedge clk);
        #1;
        chk("abort_ready_next", bus0.step_ready, 1);
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus0.out_valid !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        chk("abort_no_ov", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/snn_layer_controller.md
SNN_LAYER_CONTROLLER -- requirements
Module: snn_layer_controller

Interface
REQ-001 SHALL have parameter NUM_IN, default 8: number of input spike channels.
REQ-002 SHALL have parameter NUM_OUT, default 8: number of output neurons.
REQ-003 SHALL have parameter W_WIDTH, default 8: signed synaptic weight width.
REQ-004 SHALL have parameter V_WIDTH, default 16: signed membrane potential width.
REQ-005 SHALL have parameter THRESHOLD, default 64: firing threshold, positive, representable in V_WIDTH.
REQ-006 SHALL have parameter LEAK_SHIFT, default 3: leak = v >>> LEAK_SHIFT (arithmetic shift).
REQ-007 SHALL have parameter REFRAC, default 2: refractory steps after a spike.
REQ-008 SHALL have parameter RESET_MODE, default 0: 0 = zero on fire, 1 = subtract THRESHOLD on fire.
REQ-009 SHALL have one clock and a synchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-010 reset_n  input  1  synchronous active-low reset.
REQ-011 input_spike  input  NUM_IN  spike vector for one time step.
REQ-012 step_valid  input  1  input_spike valid.
REQ-013 step_ready  output  1  block can accept a step.
REQ-014 w_we  input  1  weight write strobe.
REQ-015 w_addr_in  input  clog2(NUM_IN)  weight row (presynaptic index).
REQ-016 w_addr_out  input  clog2(NUM_OUT)  weight column (neuron index).
REQ-017 w_data  input  W_WIDTH  signed weight value.
REQ-018 output_spike  output  NUM_OUT  registered spike vector of the last step.
REQ-019 out_valid  output  1  one-cycle pulse: output_spike updated.

Function
REQ-020 SHALL implement states IDLE, ACCUM, FIRE; step_ready = 1 only in IDLE.
REQ-021 On step_valid & step_ready at an edge: capture input_spike, clear index i, go to ACCUM.
REQ-022 ACCUM SHALL last exactly NUM_IN cycles; in cycle i, if captured bit i = 1, v[j] += w[i][j] for all j in parallel; then go to FIRE.
REQ-023 All additions SHALL saturate to [-2^(V_WIDTH-1), 2^(V_WIDTH-1)-1]; weights sign-extended.
REQ-024 FIRE (one cycle), per neuron j: if refrac[j] > 0: v[j] <= 0, refrac[j] decrements, spike 0.
REQ-025 Else vl = v[j] - (v[j] >>> LEAK_SHIFT); if vl >= THRESHOLD: spike 1, refrac[j] <= REFRAC, v[j] <= 0 (mode 0) or vl - THRESHOLD (mode 1); else spike 0, v[j] <= vl.
REQ-026 At the edge ending FIRE: output_spike and out_valid = 1 register, state returns to IDLE; out_valid is high NUM_IN+1 edges after the accepting edge, for one cycle.
REQ-027 output_spike SHALL hold its value until the next FIRE completes.
REQ-028 step_valid outside IDLE SHALL be ignored (no capture, no queueing).
REQ-029 w_we in IDLE SHALL write w[w_addr_in][w_addr_out] <= w_data; w_we outside IDLE, or with out-of-range address, SHALL be ignored.
REQ-030 w_we and an accepted step in the same IDLE cycle: write SHALL take effect before ACCUM reads it.

Reset
REQ-031 reset_n = 0 at an edge SHALL force IDLE, output_spike = 0, out_valid = 0, all v = 0, all refrac = 0, all weights = 0.
REQ-032 Reset in ACCUM or FIRE SHALL abort the step; no out_valid pulse follows.
REQ-033 step_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-034 Reset: reset_n low one edge -> output_spike = 8'h00, out_valid = 0, step_ready = 1.
REQ-035 All weights 10, input 8'hFF -> v = 80, leak 10, 70 >= 64 -> output_spike = 8'hFF, out_valid 9 edges after acceptance, step_ready low for those cycles.
REQ-036 Refractory: after REQ-035, three more 8'hFF steps -> outputs 8'h00, 8'h00, 8'hFF.
REQ-037 Leak: w[0][0] = 40 only, input 8'h01 twice -> step 1 v = 35, output 8'h00; step 2 v = 75 - 9 = 66 -> output 8'h01.
REQ-038 RESET_MODE = 1 with REQ-035 stimulus -> 8'hFF, residual v = 6; during refractory steps v forced to 0.
REQ-039 Handshake: step_valid held high through a step, w_we of 127 issued during ACCUM -> exactly one capture per IDLE visit, weight unchanged; reset_n low in ACCUM -> no out_valid, step_ready = 1 next cycle.
